paddle_bbox_tracker: RTL and testbench

Per-frame paddle tracker downstream of the colour-threshold / paddle-localization stage. Consumes the two per-pixel target masks (target 1, target 2) with the pixel's row/col and valid strobe. Accumulates a bounding box and pixel count per target over each frame. At frame end, publishes a centroid (bounding-box midpoint), count and found flag for each target to the game logic.

---
 rtl/paddle_pkg.sv | 19 +
 rtl/bbox_accumulator.sv | 73 +++++++
 rtl/paddle_bbox_tracker.sv | 165 ++++++++++++++++
 tb/tb_paddle_bbox_tracker.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/paddle_pkg.sv
// Shared types and default geometry for the paddle tracking path.
package paddle_pkg;

    localparam int DEFAULT_WIDTH      = 640;
    localparam int DEFAULT_HEIGHT     = 480;
    localparam int DEFAULT_MIN_PIXELS = 64;
    localparam int COORD_W            = 13;
    localparam int COUNT_W            = 19;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [COUNT_W-1:0] count_t;

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2
    } state_t;

endpackage

// File: rtl/bbox_accumulator.sv
// Per-target bounding box and saturating pixel counter for one frame.
module bbox_accumulator
    import paddle_pkg::*;
#(
    parameter int COORD_WIDTH = COORD_W,
    parameter int COUNT_WIDTH = COUNT_W
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   enable,
    input  logic                   mask,
    input  logic [COORD_WIDTH-1:0] row,
    input  logic [COORD_WIDTH-1:0] col,
    output logic [COORD_WIDTH-1:0] xmin,
    output logic [COORD_WIDTH-1:0] xmax,
    output logic [COORD_WIDTH-1:0] ymin,
    output logic [COORD_WIDTH-1:0] ymax,
    output logic [COUNT_WIDTH-1:0] count
);

    logic empty;
    logic hit;

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (&v) ? v : v + COUNT_WIDTH'(1);
    endfunction

    assign hit = enable & mask;

    // clear together with enable means the clearing beat is also the first pixel
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            xmin  <= '0;
            xmax  <= '0;
            ymin  <= '0;
            ymax  <= '0;
            count <= '0;
            empty <= 1'b1;
        end else if (clear) begin
            if (hit) begin
                xmin  <= col;
                xmax  <= col;
                ymin  <= row;
                ymax  <= row;
                count <= COUNT_WIDTH'(1);
                empty <= 1'b0;
            end else begin
                xmin  <= '0;
                xmax  <= '0;
                ymin  <= '0;
                ymax  <= '0;
                count <= '0;
                empty <= 1'b1;
            end
        end else if (hit) begin
            if (empty) begin
                xmin <= col;
                xmax <= col;
                ymin <= row;
                ymax <= row;
            end else begin
                if (col < xmin) xmin <= col;
                if (col > xmax) xmax <= col;
                if (row < ymin) ymin <= row;
                if (row > ymax) ymax <= row;
            end
            count <= sat_inc(count);
            empty <= 1'b0;
        end
    end

endmodule

// File: rtl/paddle_bbox_tracker.sv
// Frame-synchronised two-target bounding-box tracker publishing centroid,
// count and found flag once per completed frame.
module paddle_bbox_tracker
    import paddle_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int HEIGHT      = DEFAULT_HEIGHT,
    parameter int COORD_WIDTH = COORD_W,
    parameter int COUNT_WIDTH = COUNT_W,
    parameter int MIN_PIXELS  = DEFAULT_MIN_PIXELS
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    input  logic [COORD_WIDTH-1:0] row,
    input  logic [COORD_WIDTH-1:0] col,
    input  logic                   mask1,
    input  logic                   mask2,
    output logic                   out_valid,
    output logic                   found1,
    output logic                   found2,
    output logic [COORD_WIDTH-1:0] cx1,
    output logic [COORD_WIDTH-1:0] cx2,
    output logic [COORD_WIDTH-1:0] cy1,
    output logic [COORD_WIDTH-1:0] cy2,
    output logic [COUNT_WIDTH-1:0] count1,
    output logic [COUNT_WIDTH-1:0] count2
);

    localparam logic [COORD_WIDTH-1:0] LAST_ROW = COORD_WIDTH'(HEIGHT - 1);
    localparam logic [COORD_WIDTH-1:0] LAST_COL = COORD_WIDTH'(WIDTH - 1);
    localparam logic [COORD_WIDTH-1:0] ROW_LIM  = COORD_WIDTH'(HEIGHT);
    localparam logic [COORD_WIDTH-1:0] COL_LIM  = COORD_WIDTH'(WIDTH);
    localparam logic [COUNT_WIDTH-1:0] MIN_CNT  = COUNT_WIDTH'(MIN_PIXELS);

    state_t state;

    logic in_range;
    logic is_start;
    logic is_end;
    logic acc_clear;
    logic acc_en;

    logic [COORD_WIDTH-1:0] xmin1, xmax1, ymin1, ymax1;
    logic [COORD_WIDTH-1:0] xmin2, xmax2, ymin2, ymax2;
    logic [COUNT_WIDTH-1:0] acc_count1, acc_count2;
    logic                   hit1, hit2;

    // Sum at one extra bit so the midpoint never wraps.
    function automatic logic [COORD_WIDTH-1:0] midpoint(input logic [COORD_WIDTH-1:0] a,
                                                        input logic [COORD_WIDTH-1:0] b);
        logic [COORD_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[COORD_WIDTH:1];
    endfunction

    assign in_range = (row < ROW_LIM) && (col < COL_LIM);
    assign is_start = in_valid && (row == '0) && (col == '0);
    assign is_end   = in_valid && (row == LAST_ROW) && (col == LAST_COL);
    assign hit1     = acc_count1 >= MIN_CNT;
    assign hit2     = acc_count2 >= MIN_CNT;

    always_comb begin
        acc_clear = 1'b0;
        acc_en    = 1'b0;
        case (state)
            SYNC: begin
                if (is_start) begin
                    acc_clear = 1'b1;
                    acc_en    = 1'b1;
                end
            end
            ACCUM: begin
                if (is_start) begin
                    acc_clear = 1'b1;
                    acc_en    = 1'b1;
                end else if (in_valid && in_range) begin
                    acc_en = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    bbox_accumulator #(
        .COORD_WIDTH(COORD_WIDTH),
        .COUNT_WIDTH(COUNT_WIDTH)
    ) u_acc1 (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (acc_clear),
        .enable (acc_en),
        .mask   (mask1),
        .row    (row),
        .col    (col),
        .xmin   (xmin1),
        .xmax   (xmax1),
        .ymin   (ymin1),
        .ymax   (ymax1),
        .count  (acc_count1)
    );

    bbox_accumulator #(
        .COORD_WIDTH(COORD_WIDTH),
        .COUNT_WIDTH(COUNT_WIDTH)
    ) u_acc2 (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (acc_clear),
        .enable (acc_en),
        .mask   (mask2),
        .row    (row),
        .col    (col),
        .xmin   (xmin2),
        .xmax   (xmax2),
        .ymin   (ymin2),
        .ymax   (ymax2),
        .count  (acc_count2)
    );

    // REPORT samples the accumulators after the frame-end beat has landed in them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= SYNC;
            out_valid <= 1'b0;
            found1    <= 1'b0;
            found2    <= 1'b0;
            cx1       <= '0;
            cx2       <= '0;
            cy1       <= '0;
            cy2       <= '0;
            count1    <= '0;
            count2    <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                SYNC: begin
                    if (is_start) state <= is_end ? REPORT : ACCUM;
                end
                ACCUM: begin
                    if (is_end) state <= REPORT;
                end
                REPORT: begin
                    state     <= SYNC;
                    out_valid <= 1'b1;
                    found1    <= hit1;
                    found2    <= hit2;
                    count1    <= acc_count1;
                    count2    <= acc_count2;
                    if (hit1) begin
                        cx1 <= midpoint(xmin1, xmax1);
                        cy1 <= midpoint(ymin1, ymax1);
                    end
                    if (hit2) begin
                        cx2 <= midpoint(xmin2, xmax2);
                        cy2 <= midpoint(ymin2, ymax2);
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_paddle_bbox_tracker.sv
// Directed bench for paddle_bbox_tracker: default threshold and MIN_PIXELS=1 instances.
module tb_paddle_bbox_tracker;
    import paddle_pkg::*;

    logic   clk = 1'b0;
    logic   reset_n;
    logic   in_valid;
    coord_t row;
    coord_t col;
    logic   mask1;
    logic   mask2;

    logic   out_valid, found1, found2;
    coord_t cx1, cx2, cy1, cy2;
    count_t count1, count2;

    logic   b_out_valid, b_found1, b_found2;
    coord_t b_cx1, b_cx2, b_cy1, b_cy2;
    count_t b_count1, b_count2;

    int n_tests = 0;
    int n_fail  = 0;
    int pulses  = 0;
    int p0;

    always #5 clk = ~clk;

    paddle_bbox_tracker dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .row(row), .col(col),
        .mask1(mask1), .mask2(mask2), .out_valid(out_valid),
        .found1(found1), .found2(found2), .cx1(cx1), .cx2(cx2),
        .cy1(cy1), .cy2(cy2), .count1(count1), .count2(count2)
    );

    paddle_bbox_tracker #(.MIN_PIXELS(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .row(row), .col(col),
        .mask1(mask1), .mask2(mask2), .out_valid(b_out_valid),
        .found1(b_found1), .found2(b_found2), .cx1(b_cx1), .cx2(b_cx2),
        .cy1(b_cy1), .cy2(b_cy2), .count1(b_count1), .count2(b_count2)
    );

    always @(negedge clk) if (out_valid) pulses++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_res(input string t, input bit use_b,
                             input int f1, input int x1, input int y1, input int c1,
                             input int f2, input int x2, input int y2, input int c2);
        if (!use_b) begin
            check_eq({t, ".found1"}, 32'(found1), f1);
            check_eq({t, ".cx1"},    32'(cx1),    x1);
            check_eq({t, ".cy1"},    32'(cy1),    y1);
            check_eq({t, ".count1"}, 32'(count1), c1);
            check_eq({t, ".found2"}, 32'(found2), f2);
            check_eq({t, ".cx2"},    32'(cx2),    x2);
            check_eq({t, ".cy2"},    32'(cy2),    y2);
            check_eq({t, ".count2"}, 32'(count2), c2);
        end else begin
            check_eq({t, ".b.found1"}, 32'(b_found1), f1);
            check_eq({t, ".b.cx1"},    32'(b_cx1),    x1);
            check_eq({t, ".b.cy1"},    32'(b_cy1),    y1);
            check_eq({t, ".b.count1"}, 32'(b_count1), c1);
            check_eq({t, ".b.found2"}, 32'(b_found2), f2);
            check_eq({t, ".b.cx2"},    32'(b_cx2),    x2);
            check_eq({t, ".b.cy2"},    32'(b_cy2),    y2);
            check_eq({t, ".b.count2"}, 32'(b_count2), c2);
        end
    endtask

    task automatic beat(input logic v, input int r, input int c, input logic m1, input logic m2);
        @(negedge clk);
        in_valid = v;
        row      = r[COORD_W-1:0];
        col      = c[COORD_W-1:0];
        mask1    = m1;
        mask2    = m2;
    endtask

    task automatic idle(input int n);
        repeat (n) beat(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic block(input int r0, input int c0, input int nr, input int nc,
                         input logic m1, input logic m2, input bit gaps);
        for (int r = r0; r < r0 + nr; r++) begin
            for (int c = c0; c < c0 + nc; c++) begin
                if (gaps) while ($urandom_range(0, 9) < 3) idle(1);
                beat(1'b1, r, c, m1, m2);
            end
        end
    endtask

    // Frame-end beat, then out_valid must be low after the sampling edge,
    // high after the next edge, and low again one edge later.
    task automatic frame_end(input string t, input logic m1, input logic m2);
        beat(1'b1, 479, 639, m1, m2);
        @(posedge clk); #1;
        check_eq({t, ".ov_e0"}, 32'(out_valid), 0);
        @(negedge clk);
        in_valid = 1'b0;
        mask1    = 1'b0;
        mask2    = 1'b0;
        @(posedge clk); #1;
        check_eq({t, ".ov_e1"}, 32'(out_valid), 1);
        @(posedge clk); #1;
        check_eq({t, ".ov_e2"}, 32'(out_valid), 0);
    endtask

    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b0;
        row      = '0;
        col      = '0;
        mask1    = 1'b0;
        mask2    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst.out_valid", 32'(out_valid), 0);
        check_res("rst", 1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        idle(2);

        // 10x10 block of target 1
        p0 = pulses;
        beat(1'b1, 0, 0, 1'b0, 1'b0);
        block(200, 100, 10, 10, 1'b1, 1'b0, 1'b0);
        frame_end("t1", 1'b0, 1'b0);
        check_res("t1", 1'b0, 1, 104, 204, 100, 0, 0, 0, 0);
        check_eq("t1.pulses", 32'(pulses - p0), 1);
        idle(2);

        // too few pixels: count updates, centroid coasts
        beat(1'b1, 0, 0, 1'b0, 1'b0);
        block(50, 20, 1, 10, 1'b1, 1'b0, 1'b0);
        frame_end("t2", 1'b0, 1'b0);
        check_res("t2", 1'b0, 0, 104, 204, 10, 0, 0, 0, 0);
        idle(2);

        // mid-frame reset, then beats starting at row 37 must be ignored
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_res("rst2", 1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        p0 = pulses;
        beat(1'b1, 37, 0, 1'b1, 1'b1);
        block(37, 5, 2, 3, 1'b1, 1'b1, 1'b0);
        beat(1'b1, 400, 600, 1'b1, 1'b0);
        beat(1'b1, 479, 639, 1'b1, 1'b1);
        idle(5);
        check_eq("t3.no_pulse", 32'(pulses - p0), 0);
        check_eq("t3.count1_idle", 32'(count1), 0);
        beat(1'b1, 0, 0, 1'b0, 1'b0);
        block(200, 100, 10, 10, 1'b1, 1'b0, 1'b0);
        frame_end("t3", 1'b0, 1'b0);
        check_res("t3", 1'b0, 1, 104, 204, 100, 0, 0, 0, 0);
        check_eq("t3.pulses", 32'(pulses - p0), 1);
        idle(2);

        // restart mid-frame: first 50 pixels (both masks) discarded
        p0 = pulses;
        beat(1'b1, 0, 0, 1'b0, 1'b0);
        block(10, 0, 1, 50, 1'b1, 1'b1, 1'b0);
        beat(1'b1, 300, 5, 1'b0, 1'b0);
        beat(1'b1, 0, 0, 1'b0, 1'b0);
        block(60, 300, 8, 8, 1'b1, 1'b0, 1'b0);
        frame_end("t4", 1'b0, 1'b0);
        check_eq("t4.pulses", 32'(pulses - p0), 1);
        check_res("t4", 1'b0, 1, 303, 63, 64, 0, 0, 0, 0);
        idle(2);

        // same image as the first frame, with random idle cycles
        beat(1'b1, 0, 0, 1'b0, 1'b0);
        block(200, 100, 10, 10, 1'b1, 1'b0, 1'b1);
        frame_end("t5", 1'b0, 1'b0);
        check_res("t5", 1'b0, 1, 104, 204, 100, 0, 0, 0, 0);
        idle(2);

        // corner pixels on both masks, out-of-range beats ignored
        beat(1'b1, 0, 0, 1'b1, 1'b1);
        beat(1'b1, 5, 640, 1'b1, 1'b1);
        beat(1'b1, 480, 5, 1'b1, 1'b1);
        frame_end("t6", 1'b1, 1'b1);
        check_res("t6", 1'b1, 1, 319, 239, 2, 1, 319, 239, 2);
        check_res("t6", 1'b0, 0, 104, 204, 2, 0, 0, 0, 2);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
